// File: rtl/skintone_job_sequencer.sv
// skintone_job_sequencer: runs one skintone job at a time.
// Writes config words, issues the opcode, then gates pixel/result beats.
module skintone_job_sequencer #(
  parameter int C_DATA_WIDTH           = 128,
  parameter int C_CONFIG_ADDRESS_WIDTH = 36,
  parameter int C_CONFIG_DATA_WIDTH    = 128,
  parameter int C_OPCODE_WIDTH         = 16,
  parameter int C_NUM_CFG              = 4,
  parameter int C_CNT_WIDTH            = 24,
  parameter int C_TIMEOUT              = 255
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      job_start,
  input  logic [C_OPCODE_WIDTH-1:0]                 job_opcode,
  input  logic [C_CNT_WIDTH-1:0]                    job_beats,
  input  logic [C_CONFIG_ADDRESS_WIDTH-1:0]         job_cfg_base,
  input  logic [C_NUM_CFG*C_CONFIG_DATA_WIDTH-1:0]  job_cfg_words,
  output logic                                      job_busy,
  output logic                                      job_done,
  output logic                                      job_error,
  input  logic [C_DATA_WIDTH-1:0]                   src_data,
  input  logic                                      src_valid,
  output logic                                      src_ready,
  output logic [C_DATA_WIDTH-1:0]                   pixel_datain,
  output logic                                      pixel_datain_valid,
  input  logic                                      pixel_datain_ready,
  input  logic [C_DATA_WIDTH-1:0]                   result_dataout,
  input  logic                                      result_dataout_valid,
  output logic                                      result_dataout_ready,
  output logic [C_DATA_WIDTH-1:0]                   sink_data,
  output logic                                      sink_valid,
  input  logic                                      sink_ready,
  output logic [C_CONFIG_ADDRESS_WIDTH-1:0]         config_address,
  output logic [C_CONFIG_DATA_WIDTH-1:0]            config_datain,
  output logic                                      config_wrreq,
  input  logic                                      config_wrack,
  output logic [C_OPCODE_WIDTH-1:0]                 opcode,
  output logic                                      opcode_valid,
  input  logic                                      opcode_accept
);

  localparam int IW = (C_NUM_CFG > 1) ? $clog2(C_NUM_CFG) : 1;
  localparam int TW = $clog2(C_TIMEOUT + 1);
  localparam int AW = C_CONFIG_ADDRESS_WIDTH;
  localparam int DW = C_CONFIG_DATA_WIDTH;
  localparam int CW = C_CNT_WIDTH;
  localparam logic [IW-1:0] LAST_IDX = IW'(C_NUM_CFG - 1);
  localparam logic [TW-1:0] TMR_LAST = TW'(C_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CFG,
    S_OPC,
    S_STREAM,
    S_DONE,
    S_ERR
  } state_t;

  state_t                    state_q, state_d;
  logic [IW-1:0]             idx_q, idx_d;
  logic [TW-1:0]             tmr_q, tmr_d;
  logic [CW-1:0]             sent_q, sent_d;
  logic [CW-1:0]             rcvd_q, rcvd_d;
  logic [CW-1:0]             beats_q, beats_d;
  logic [AW-1:0]             base_q, base_d;
  logic [C_OPCODE_WIDTH-1:0] opc_q, opc_d;
  logic                      err_q, err_d;
  logic [DW-1:0]             cfg_q [C_NUM_CFG];
  logic [DW-1:0]             cfg_d [C_NUM_CFG];

  logic more;
  logic pix_fire;
  logic res_fire;

  assign more     = (sent_q < beats_q);
  assign pix_fire = src_valid & pixel_datain_ready & more;
  assign res_fire = result_dataout_valid & sink_ready;

  assign sink_data            = result_dataout;
  assign sink_valid           = result_dataout_valid;
  assign result_dataout_ready = sink_ready;

  assign config_address = base_q + AW'(idx_q);
  assign config_datain  = cfg_q[idx_q];
  assign opcode         = opc_q;
  assign job_error      = err_q;

  // State and job registers; reset aborts any job in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      tmr_q   <= '0;
      sent_q  <= '0;
      rcvd_q  <= '0;
      beats_q <= '0;
      base_q  <= '0;
      opc_q   <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < C_NUM_CFG; i++) cfg_q[i] <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      tmr_q   <= tmr_d;
      sent_q  <= sent_d;
      rcvd_q  <= rcvd_d;
      beats_q <= beats_d;
      base_q  <= base_d;
      opc_q   <= opc_d;
      err_q   <= err_d;
      for (int i = 0; i < C_NUM_CFG; i++) cfg_q[i] <= cfg_d[i];
    end
  end

  // Next-state, handshake and stream-gating logic.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    tmr_d   = tmr_q;
    sent_d  = sent_q;
    rcvd_d  = rcvd_q;
    beats_d = beats_q;
    base_d  = base_q;
    opc_d   = opc_q;
    err_d   = err_q;
    for (int i = 0; i < C_NUM_CFG; i++) cfg_d[i] = cfg_q[i];
    job_busy           = 1'b0;
    job_done           = 1'b0;
    config_wrreq       = 1'b0;
    opcode_valid       = 1'b0;
    pixel_datain       = '0;
    pixel_datain_valid = 1'b0;
    src_ready          = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (job_start) begin
          idx_d   = '0;
          tmr_d   = '0;
          sent_d  = '0;
          rcvd_d  = '0;
          beats_d = job_beats;
          base_d  = job_cfg_base;
          opc_d   = job_opcode;
          err_d   = 1'b0;
          for (int i = 0; i < C_NUM_CFG; i++)
            cfg_d[i] = job_cfg_words[i*DW +: DW];
          state_d = S_CFG;
        end
      end
      S_CFG: begin
        job_busy     = 1'b1;
        config_wrreq = 1'b1;
        if (config_wrack) begin
          tmr_d = '0;
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = S_OPC;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end else if (tmr_q == TMR_LAST) begin
          err_d   = 1'b1;
          state_d = S_ERR;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      S_OPC: begin
        job_busy     = 1'b1;
        opcode_valid = 1'b1;
        if (opcode_accept) begin
          tmr_d = '0;
          if (beats_q == '0) state_d = S_DONE;
          else state_d = S_STREAM;
        end else if (tmr_q == TMR_LAST) begin
          err_d   = 1'b1;
          state_d = S_ERR;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      S_STREAM: begin
        job_busy           = 1'b1;
        pixel_datain       = src_data;
        pixel_datain_valid = src_valid & more;
        src_ready          = pixel_datain_ready & more;
        if (pix_fire) sent_d = sent_q + CW'(1);
        rcvd_d = rcvd_q + CW'(res_fire);
        if (rcvd_d == beats_q) state_d = S_DONE;
      end
      S_DONE: begin
        job_done = 1'b1;
        state_d  = S_IDLE;
      end
      S_ERR: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_skintone_job_sequencer.sv
// tb_skintone_job_sequencer: vector table, hand sequences and
// randomized jobs checked against a transaction-level model.
module tb_skintone_job_sequencer;

  localparam int DW  = 128;
  localparam int AW  = 36;
  localparam int CDW = 128;
  localparam int OW  = 16;
  localparam int NC  = 4;
  localparam int CW  = 24;
  localparam int TO  = 255;
  localparam logic [DW-1:0] SRC0 = 128'h5a5a_0000_1111_2222_3333_4444_0000_0000;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 job_start;
  logic [OW-1:0]        job_opcode;
  logic [CW-1:0]        job_beats;
  logic [AW-1:0]        job_cfg_base;
  logic [NC*CDW-1:0]    job_cfg_words;
  logic                 job_busy, job_done, job_error;
  logic [DW-1:0]        src_data;
  logic                 src_valid, src_ready;
  logic [DW-1:0]        pixel_datain;
  logic                 pixel_datain_valid, pixel_datain_ready;
  logic [DW-1:0]        result_dataout;
  logic                 result_dataout_valid, result_dataout_ready;
  logic [DW-1:0]        sink_data;
  logic                 sink_valid, sink_ready;
  logic [AW-1:0]        config_address;
  logic [CDW-1:0]       config_datain;
  logic                 config_wrreq, config_wrack;
  logic [OW-1:0]        opcode;
  logic                 opcode_valid, opcode_accept;

  always #5 clk = ~clk;

  skintone_job_sequencer #(
    .C_DATA_WIDTH(DW), .C_CONFIG_ADDRESS_WIDTH(AW),
    .C_CONFIG_DATA_WIDTH(CDW), .C_OPCODE_WIDTH(OW),
    .C_NUM_CFG(NC), .C_CNT_WIDTH(CW), .C_TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .job_start(job_start), .job_opcode(job_opcode),
    .job_beats(job_beats), .job_cfg_base(job_cfg_base),
    .job_cfg_words(job_cfg_words),
    .job_busy(job_busy), .job_done(job_done), .job_error(job_error),
    .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
    .pixel_datain(pixel_datain), .pixel_datain_valid(pixel_datain_valid),
    .pixel_datain_ready(pixel_datain_ready),
    .result_dataout(result_dataout),
    .result_dataout_valid(result_dataout_valid),
    .result_dataout_ready(result_dataout_ready),
    .sink_data(sink_data), .sink_valid(sink_valid), .sink_ready(sink_ready),
    .config_address(config_address), .config_datain(config_datain),
    .config_wrreq(config_wrreq), .config_wrack(config_wrack),
    .opcode(opcode), .opcode_valid(opcode_valid),
    .opcode_accept(opcode_accept)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: got %h want %h", nm, act, want);
    end
  endtask

  // datapath model: fixed transform, one result per pixel, in order
  function automatic logic [DW-1:0] dp_f(input logic [DW-1:0] x);
    return {x[63:0], x[127:64]} ^ 128'hc3c3_1e1e_0f0f_a5a5_c3c3_1e1e_0f0f_a5a5;
  endfunction

  // environment state
  bit  env_on = 0, stall = 0, src_hold = 0;
  int  wr_dly = 0, op_dly = 0, wr_wait = 0, op_wait = 0;
  int  src_idx = 0, cyc = 0;
  int  wr_cyc, opv_cyc, srdy_cyc, done_cnt, busy_at_done, opc_cyc, done_cyc;
  logic [DW-1:0]  dp_q [$];
  logic [DW-1:0]  pix_log [$];
  logic [DW-1:0]  sink_log [$];
  logic [AW-1:0]  cfga_log [$];
  logic [CDW-1:0] cfgd_log [$];
  logic [OW-1:0]  opc_log [$];
  logic [CDW-1:0] cw [NC];

  task automatic clear_logs();
    dp_q.delete(); pix_log.delete(); sink_log.delete();
    cfga_log.delete(); cfgd_log.delete(); opc_log.delete();
    wr_cyc = 0; opv_cyc = 0; srdy_cyc = 0; done_cnt = 0;
    busy_at_done = 0; opc_cyc = -10; done_cyc = -20; src_idx = 0;
  endtask

  // responders and stream sources, driven just after each rising edge
  initial begin
    forever begin
      @(posedge clk); #1;
      if (env_on) begin
        if (config_wrreq && wr_dly >= 0) begin
          if (wr_wait >= wr_dly) begin config_wrack = 1; wr_wait = 0; end
          else begin config_wrack = 0; wr_wait++; end
        end else begin
          config_wrack = 0; wr_wait = 0;
        end
        if (opcode_valid && op_dly >= 0) begin
          if (op_wait >= op_dly) begin opcode_accept = 1; op_wait = 0; end
          else begin opcode_accept = 0; op_wait++; end
        end else begin
          opcode_accept = 0; op_wait = 0;
        end
        src_valid = !src_hold && (!stall || $urandom_range(3) != 0);
        src_data = SRC0 + DW'(src_idx);
        pixel_datain_ready = !stall || $urandom_range(2) != 0;
        sink_ready = !stall || $urandom_range(2) != 0;
        result_dataout_valid = dp_q.size() > 0 && (!stall || $urandom_range(1) != 0);
        result_dataout = (dp_q.size() > 0) ? dp_q[0] : '0;
      end
    end
  end

  // monitors, sampled on the falling edge
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (env_on && !rst) begin
        if (config_wrreq) wr_cyc++;
        if (config_wrreq && config_wrack) begin
          cfga_log.push_back(config_address);
          cfgd_log.push_back(config_datain);
        end
        if (opcode_valid) opv_cyc++;
        if (opcode_valid && opcode_accept) begin
          opc_log.push_back(opcode);
          opc_cyc = cyc;
        end
        if (src_ready) srdy_cyc++;
        if (src_valid && src_ready) src_idx++;
        if (result_dataout_valid && result_dataout_ready && dp_q.size() > 0)
          void'(dp_q.pop_front());
        if (sink_valid && sink_ready) sink_log.push_back(sink_data);
        if (pixel_datain_valid && pixel_datain_ready) begin
          pix_log.push_back(pixel_datain);
          dp_q.push_back(dp_f(pixel_datain));
        end
        if (job_done) begin
          done_cnt++;
          done_cyc = cyc;
          if (job_busy) busy_at_done++;
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic start_job(input logic [OW-1:0] opc, input int beats,
                           input logic [AW-1:0] base);
    for (int i = 0; i < NC; i++)
      cw[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
    @(posedge clk); #1;
    job_opcode = opc;
    job_beats = CW'(beats);
    job_cfg_base = base;
    for (int i = 0; i < NC; i++) job_cfg_words[i*CDW +: CDW] = cw[i];
    job_start = 1;
    @(posedge clk); #1;
    job_start = 0;
  endtask

  task automatic run_job(input string tag, input logic [OW-1:0] opc,
                         input int beats, input logic [AW-1:0] base,
                         input int wd, input int od, input bit poke);
    int n;
    clear_logs();
    wr_dly = wd;
    op_dly = od;
    start_job(opc, beats, base);
    if (poke) begin
      repeat (3) @(posedge clk);
      #1;
      job_opcode = ~opc;
      job_start = 1;
      @(posedge clk); #1;
      job_start = 0;
      job_opcode = opc;
    end
    n = 0;
    while (job_busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_ends"}, n < 3000, 1);
    repeat (6) @(negedge clk);
  endtask

  // expected results derived from the job description alone
  task automatic check_job(input string tag, input logic [OW-1:0] opc,
                           input int beats, input logic [AW-1:0] base,
                           input int wd, input int od);
    logic [AW-1:0] a;
    chk({tag, "_cfg_n"}, cfga_log.size(), NC);
    for (int i = 0; i < NC && i < cfga_log.size(); i++) begin
      a = base + AW'(i);
      chk($sformatf("%s_cfg_addr%0d", tag, i), cfga_log[i], a);
      chk($sformatf("%s_cfg_data%0d", tag, i), cfgd_log[i], cw[i]);
    end
    chk({tag, "_wr_cycles"}, wr_cyc, NC * (wd + 1));
    chk({tag, "_opc_n"}, opc_log.size(), 1);
    if (opc_log.size() > 0) chk({tag, "_opc"}, opc_log[0], opc);
    chk({tag, "_opv_cycles"}, opv_cyc, od + 1);
    chk({tag, "_pix_n"}, pix_log.size(), beats);
    for (int k = 0; k < beats && k < pix_log.size(); k++)
      chk($sformatf("%s_pix%0d", tag, k), pix_log[k], SRC0 + DW'(k));
    chk({tag, "_sink_n"}, sink_log.size(), beats);
    for (int k = 0; k < beats && k < sink_log.size(); k++)
      chk($sformatf("%s_sink%0d", tag, k), sink_log[k], dp_f(SRC0 + DW'(k)));
    chk({tag, "_done_n"}, done_cnt, 1);
    chk({tag, "_busy_at_done"}, busy_at_done, 0);
    chk({tag, "_src_taken"}, src_idx, beats);
    chk({tag, "_err"}, job_error, 0);
  endtask

  typedef struct packed {
    logic [6:0]    in;   // st wack oacc sv pr rv kr
    logic [5:0]    ex;   // busy done wrreq opv srdy pvld
    logic [AW-1:0] addr;
  } vec_t;

  vec_t tbl [16];

  function automatic vec_t mk(input logic [6:0] i, input logic [5:0] e,
                              input logic [AW-1:0] a);
    vec_t v;
    v.in = i; v.ex = e; v.addr = a;
    return v;
  endfunction

  initial begin
    int n;
    int k;
    logic [OW-1:0] ro;
    int rb, rwd, rod;
    logic [AW-1:0] rbase;

    rst = 1; job_start = 0; job_opcode = '0; job_beats = '0;
    job_cfg_base = '0; job_cfg_words = '0; src_data = '0; src_valid = 0;
    pixel_datain_ready = 0; result_dataout = '0; result_dataout_valid = 0;
    sink_ready = 0; config_wrack = 0; opcode_accept = 0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_ctl", {job_busy, job_done, job_error, config_wrreq,
                      opcode_valid, src_ready, pixel_datain_valid}, 0);
    chk("reset_addr", config_address, 0);
    chk("reset_data", config_datain, 0);
    chk("reset_opcode", opcode, 0);
    rst = 0;

    // table: base 0x100, 2 beats, opcode 0x1234
    for (int i = 0; i < NC; i++) cw[i] = {4{32'h1000_0000 + 32'(i)}};
    job_opcode = 16'h1234;
    job_beats = 24'd2;
    job_cfg_base = 36'h100;
    for (int i = 0; i < NC; i++) job_cfg_words[i*CDW +: CDW] = cw[i];
    src_data = SRC0;
    result_dataout = dp_f(SRC0);
    tbl[0]  = mk(7'b0000000, 6'b000000, '0);
    tbl[1]  = mk(7'b1000000, 6'b000000, '0);
    tbl[2]  = mk(7'b0000000, 6'b101000, 36'h100);
    tbl[3]  = mk(7'b0100000, 6'b101000, 36'h100);
    tbl[4]  = mk(7'b0100000, 6'b101000, 36'h101);
    tbl[5]  = mk(7'b1000000, 6'b101000, 36'h102);
    tbl[6]  = mk(7'b0100000, 6'b101000, 36'h102);
    tbl[7]  = mk(7'b0100000, 6'b101000, 36'h103);
    tbl[8]  = mk(7'b0000000, 6'b100100, '0);
    tbl[9]  = mk(7'b0010000, 6'b100100, '0);
    tbl[10] = mk(7'b0001000, 6'b100001, '0);
    tbl[11] = mk(7'b0001100, 6'b100011, '0);
    tbl[12] = mk(7'b0001111, 6'b100011, '0);
    tbl[13] = mk(7'b0001111, 6'b100000, '0);
    tbl[14] = mk(7'b0001100, 6'b010000, '0);
    tbl[15] = mk(7'b0000000, 6'b000000, '0);
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      {job_start, config_wrack, opcode_accept, src_valid,
       pixel_datain_ready, result_dataout_valid, sink_ready} = tbl[i].in;
      @(negedge clk);
      chk($sformatf("vec%0d", i), {job_busy, job_done, config_wrreq,
          opcode_valid, src_ready, pixel_datain_valid}, tbl[i].ex);
      if (tbl[i].ex[3]) begin
        k = int'(tbl[i].addr - 36'h100);
        chk($sformatf("vec%0d_addr", i), config_address, tbl[i].addr);
        chk($sformatf("vec%0d_data", i), config_datain, cw[k]);
      end
      if (tbl[i].ex[2]) chk($sformatf("vec%0d_opc", i), opcode, 16'h1234);
    end
    job_start = 0;
    env_on = 1;

    // 8 beats, free-flowing, wrack 2 cycles late, stray start while busy
    stall = 0;
    run_job("flow8", 16'hbeef, 8, 36'h100, 2, 1, 1);
    check_job("flow8", 16'hbeef, 8, 36'h100, 2, 1);

    // 5 beats with random stalls on every stream
    stall = 1;
    run_job("stall5", 16'h0055, 5, 36'h200, 0, 0, 0);
    check_job("stall5", 16'h0055, 5, 36'h200, 0, 0);

    // wrack never comes: timeout, then a clean job clears the error
    stall = 0;
    run_job("tmo", 16'h0bad, 4, 36'h300, -1, 0, 0);
    chk("tmo_wr_cycles", wr_cyc, TO);
    chk("tmo_no_opv", opv_cyc, 0);
    chk("tmo_err", job_error, 1);
    chk("tmo_no_done", done_cnt, 0);
    chk("tmo_idle", job_busy, 0);
    run_job("post_tmo", 16'h0600, 3, 36'h340, 1, 2, 0);
    check_job("post_tmo", 16'h0600, 3, 36'h340, 1, 2);

    // zero-beat job: done the cycle after opcode accept
    run_job("zero", 16'h0000, 0, 36'h400, 1, 2, 0);
    check_job("zero", 16'h0000, 0, 36'h400, 1, 2);
    chk("zero_no_srdy", srdy_cyc, 0);
    chk("zero_done_lat", done_cyc - opc_cyc, 1);

    // reset after 3 of 8 beats, then a fresh job
    clear_logs();
    wr_dly = 0;
    op_dly = 0;
    start_job(16'h0707, 8, 36'h500);
    n = 0;
    while (pix_log.size() < 3 && n < 500) begin
      @(negedge clk); #1;
      n++;
    end
    chk("rst_reach3", n < 500, 1);
    src_hold = 1;
    rst = 1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_ctl", {job_busy, job_done, job_error, config_wrreq,
                    opcode_valid, src_ready, pixel_datain_valid}, 0);
    chk("rst_addr", config_address, 0);
    chk("rst_data", config_datain, 0);
    chk("rst_opcode", opcode, 0);
    #1;
    rst = 0;
    src_hold = 0;
    clear_logs();
    run_job("after_rst", 16'h0808, 6, 36'h500, 0, 0, 0);
    check_job("after_rst", 16'h0808, 6, 36'h500, 0, 0);

    // randomized jobs; first one wraps the config address
    stall = 1;
    for (int j = 0; j < 5; j++) begin
      ro = OW'($urandom());
      rb = $urandom_range(1, 12);
      rwd = $urandom_range(0, 3);
      rod = $urandom_range(0, 3);
      rbase = (j == 0) ? 36'hf_ffff_fffe : {4'h0, $urandom()};
      run_job($sformatf("rnd%0d", j), ro, rb, rbase, rwd, rod, 0);
      check_job($sformatf("rnd%0d", j), ro, rb, rbase, rwd, rod);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/skintone_job_sequencer.md
Name: skintone_job_sequencer

Overview:
Control sequencer in front of the skintone datapath. Takes one job request: a configuration block, an opcode and a pixel-beat count. Writes the configuration registers over the config bus, issues the opcode, then gates the pixel stream into the datapath while counting result beats back out. Reports busy/done/error to the host-side controller; one job in flight at a time.

Parameters:
C_DATA_WIDTH, 128, pixel/result beat width
C_CONFIG_ADDRESS_WIDTH, 36, config bus address width
C_CONFIG_DATA_WIDTH, 128, config bus data width
C_OPCODE_WIDTH, 16, opcode width
C_NUM_CFG, 4, config words written per job (>=1)
C_CNT_WIDTH, 24, beat counter width
C_TIMEOUT, 255, max cycles waiting for wrack or opcode_accept

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous reset, active-high
job_start  in  1  one-cycle start request; sampled only in IDLE
job_opcode  in  C_OPCODE_WIDTH  opcode for job
job_beats  in  C_CNT_WIDTH  pixel beats in job (result beats expected = same)
job_cfg_base  in  C_CONFIG_ADDRESS_WIDTH  address of first config word
job_cfg_words  in  C_NUM_CFG*C_CONFIG_DATA_WIDTH  config words; word i = bits [i*W +: W]
job_busy  out  1  high from accepted start until DONE/ERR
job_done  out  1  one-cycle pulse on success
job_error  out  1  sticky timeout flag, cleared by next accepted job_start
src_data/src_valid/src_ready  in/in/out  C_DATA_WIDTH/1/1  upstream pixel stream
pixel_datain/pixel_datain_valid/pixel_datain_ready  out/out/in  C_DATA_WIDTH/1/1  to datapath
result_dataout/result_dataout_valid/result_dataout_ready  in/in/out  C_DATA_WIDTH/1/1  from datapath
sink_data/sink_valid/sink_ready  out/out/in  C_DATA_WIDTH/1/1  downstream result stream
config_address  out  C_CONFIG_ADDRESS_WIDTH  config write address
config_datain  out  C_CONFIG_DATA_WIDTH  config write data
config_wrreq  out  1  config write request
config_wrack  in  1  config write acknowledge
opcode  out  C_OPCODE_WIDTH  opcode to datapath
opcode_valid  out  1  opcode valid
opcode_accept  in  1  opcode accepted

Behaviour:
- Reset: state IDLE; job_busy, job_done, job_error, config_wrreq, opcode_valid, pixel_datain_valid, src_ready = 0; counters, config_address, config_datain, opcode = 0. rst mid-job aborts immediately; no further bus activity.
- Job fields latched on accepted job_start (IDLE & job_start); job_start outside IDLE ignored.
- States: IDLE -> CFG -> OPC -> STREAM -> DONE -> IDLE; CFG/OPC -> ERR -> IDLE.
- CFG: word index i from 0; config_address = cfg_base + i (modulo 2^C_CONFIG_ADDRESS_WIDTH), config_datain = word i, config_wrreq held high until config_wrack. On wrack cycle: i++ and wrreq stays high for next word (back-to-back allowed); after word C_NUM_CFG-1 acked -> OPC, wrreq low. config_rdreq is not driven by this block (tie 0 at top).
- OPC: opcode_valid high, opcode = latched opcode, until opcode_accept; then -> STREAM, or -> DONE if job_beats == 0.
- Timeout: cycle counter reset on entry to CFG, each wrack, and entry to OPC; reaching C_TIMEOUT without handshake -> ERR. ERR: deassert all requests, set job_error, job_busy low next cycle, -> IDLE. No job_done.
- STREAM: combinational forward; pixel_datain = src_data; pixel_datain_valid = src_valid & (sent < beats); src_ready = pixel_datain_ready & (sent < beats). sent++ on each forwarded beat. Results: sink_data = result_dataout, sink_valid = result_dataout_valid, result_dataout_ready = sink_ready in every state; rcvd++ on each handshake while STREAM. -> DONE when rcvd reaches beats (results may finish same cycle as last pixel).
- DONE: job_done = 1 for one cycle, job_busy low same cycle, -> IDLE. Result beats outside STREAM are forwarded but not counted.
- Latency: start-to-first wrreq = 1 cycle; no added latency on streams.

Test Plan:
- C_NUM_CFG=4, base 0x100, wrack 2 cycles after each wrreq -> addresses 0x100..0x103 with matching words, one opcode handshake, no wrreq after 4th ack.
- job_beats=8, source/sink always ready, datapath echoes 1-cycle later -> exactly 8 pixel beats, 8 sink beats, job_done pulse once, busy low same cycle.
- job_beats=5 with random src_valid, pixel_datain_ready, sink_ready stalls -> no lost/duplicated beats, 6th src beat held (src_ready=0).
- wrack never asserted -> job_error=1 after 255 cycles, no opcode_valid, next job_start clears error and completes.
- job_beats=0 -> config writes and opcode only, job_done right after opcode_accept, src_ready never high.
- rst asserted mid-STREAM after 3 of 8 beats -> all outputs 0 next cycle, new job restarts from config word 0.
